// File: rtl/fattree_port_allocator_pkg.sv
// Shared constants and helpers for the fat-tree port allocator.
// Port numbering: outputs 0..K-1 are down ports, K..2K-1 are up ports.
// destport field per input is K+1 bits: bit K = direction (1 = up),
// bits K-1..0 = one-hot down target or up-port hint.
package fattree_port_allocator_pkg;

  // Number of bits needed to index n items (minimum 1).
  function automatic int clog2_int(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r = r + 1;
    return (r == 0) ? 1 : r;
  endfunction

  // Index of the first up port.
  function automatic int up_base(input int k);
    return k;
  endfunction

  // Position of the direction bit inside one destport field.
  function automatic int dir_bit(input int k);
    return k;
  endfunction

  // Width of one destport field.
  function automatic int field_w(input int k);
    return k + 1;
  endfunction

endpackage

// File: rtl/fattree_rr_arbiter.sv
// Round-robin arbiter, one per output port.
// Ports:
//   req  - request vector, one bit per input
//   ptr  - highest-priority input index this cycle
//   en   - gates the grant (output free and ready)
//   gnt  - one-hot grant, all zero when en=0 or no request
//   idx  - binary index of the selected requester (valid when |req)
module fattree_rr_arbiter #(
  parameter int P  = 8,
  parameter int Pw = 3
) (
  input  logic [P-1:0]  req,
  input  logic [Pw-1:0] ptr,
  input  logic          en,
  output logic [P-1:0]  gnt,
  output logic [Pw-1:0] idx
);

  logic found;
  int   win;
  int   j;

  always_comb begin
    found = 1'b0;
    win   = 0;
    j     = 0;
    gnt   = '0;
    for (int k = 0; k < P; k++) begin
      j = (int'(ptr) + k) % P;
      if (!found && req[j]) begin
        found = 1'b1;
        win   = j;
      end
    end
    idx = Pw'(win);
    if (found && en) gnt[win] = 1'b1;
  end

endmodule

// File: rtl/fattree_port_allocator.sv
// Wormhole output-port allocator for one fat-tree router (K down + K up).
// Heads pick a target (down: one-hot index; up: first free up port walking
// from the hint), per-output round-robin arbitration resolves conflicts, and
// a granted head without tail locks input and output until the tail passes.
// Ports:
//   clk, reset    - clock, synchronous active-high reset
//   req_valid     - [P]   flit present on input i
//   req_head      - [P]   flit is a head (destport sampled only then)
//   req_tail      - [P]   flit is a tail
//   req_destport  - [P*(K+1)] per-input {dir, one-hot port}
//   out_ready     - [P]   output o has credit
//   grant         - [P]   input i transfers this cycle (combinational)
//   out_valid     - [P]   output o carries a flit this cycle
//   out_sel       - [P*Pw] input index driving output o, 0 when idle
module fattree_port_allocator
  import fattree_port_allocator_pkg::*;
#(
  parameter int K  = 4,
  parameter int Pw = clog2_int(2 * K)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [2*K-1:0]         req_valid,
  input  logic [2*K-1:0]         req_head,
  input  logic [2*K-1:0]         req_tail,
  input  logic [2*K*(K+1)-1:0]   req_destport,
  input  logic [2*K-1:0]         out_ready,
  output logic [2*K-1:0]         grant,
  output logic [2*K-1:0]         out_valid,
  output logic [2*K*Pw-1:0]      out_sel
);

  localparam int P   = 2 * K;
  localparam int UP0 = up_base(K);
  localparam int DIR = dir_bit(K);
  localparam int FW  = field_w(K);

  logic [P-1:0]  olock;
  logic [P-1:0]  ilock;
  logic [Pw-1:0] owner [P];
  logic [Pw-1:0] iport [P];
  logic [Pw-1:0] rr    [P];

  logic [P-1:0]  tgt_vld;
  logic [Pw-1:0] tgt     [P];
  logic [P-1:0]  arb_req [P];
  logic [P-1:0]  arb_gnt [P];
  logic [Pw-1:0] arb_idx [P];
  logic [P-1:0]  lk_fire;
  logic [P-1:0]  arb_fire;

  int hot_cnt;
  int hot_idx;
  int u;

  // Target selection for unlocked heads; locked inputs bypass arbitration.
  always_comb begin
    hot_cnt = 0;
    hot_idx = 0;
    u       = 0;
    for (int i = 0; i < P; i++) begin
      tgt_vld[i] = 1'b0;
      tgt[i]     = '0;
      if (!ilock[i] && req_valid[i] && req_head[i]) begin
        hot_cnt = 0;
        hot_idx = 0;
        for (int b = 0; b < K; b++) begin
          if (req_destport[i*FW+b]) begin
            hot_cnt = hot_cnt + 1;
            hot_idx = b;
          end
        end
        // Zero or multi-hot port fields are dropped silently.
        if (hot_cnt == 1) begin
          if (!req_destport[i*FW+DIR]) begin
            tgt_vld[i] = 1'b1;
            tgt[i]     = Pw'(hot_idx);
          end else begin
            // Walk from the hint to the first up port not held by a packet.
            for (int s = 0; s < K; s++) begin
              u = (hot_idx + s) % K;
              if (!tgt_vld[i] && !olock[UP0+u]) begin
                tgt_vld[i] = 1'b1;
                tgt[i]     = Pw'(UP0 + u);
              end
            end
          end
        end
      end
    end
  end

  always_comb begin
    for (int o = 0; o < P; o++) begin
      arb_req[o] = '0;
      for (int i = 0; i < P; i++)
        arb_req[o][i] = tgt_vld[i] && (tgt[i] == Pw'(o));
    end
  end

  for (genvar o = 0; o < P; o++) begin : g_arb
    fattree_rr_arbiter #(.P(P), .Pw(Pw)) u_arb (
      .req (arb_req[o]),
      .ptr (rr[o]),
      .en  (out_ready[o] & ~olock[o]),
      .gnt (arb_gnt[o]),
      .idx (arb_idx[o])
    );
  end

  // Grant/output mux: locked outputs follow their owner, free ones the arbiter.
  always_comb begin
    grant     = '0;
    out_valid = '0;
    out_sel   = '0;
    lk_fire   = '0;
    arb_fire  = '0;
    if (!reset) begin
      for (int o = 0; o < P; o++) begin
        if (olock[o]) begin
          if (req_valid[owner[o]] && out_ready[o]) begin
            lk_fire[o]           = 1'b1;
            grant[owner[o]]      = 1'b1;
            out_valid[o]         = 1'b1;
            out_sel[o*Pw +: Pw]  = owner[o];
          end
        end else if (|arb_gnt[o]) begin
          arb_fire[o]          = 1'b1;
          grant                = grant | arb_gnt[o];
          out_valid[o]         = 1'b1;
          out_sel[o*Pw +: Pw]  = arb_idx[o];
        end
      end
    end
  end

  // Lock/pointer update; owner and iport are only meaningful under a lock.
  always_ff @(posedge clk) begin
    if (reset) begin
      olock <= '0;
      ilock <= '0;
      for (int o = 0; o < P; o++) rr[o] <= '0;
    end else begin
      for (int o = 0; o < P; o++) begin
        if (lk_fire[o] && req_tail[owner[o]]) begin
          olock[o]        <= 1'b0;
          ilock[owner[o]] <= 1'b0;
        end else if (arb_fire[o]) begin
          rr[o] <= Pw'((int'(arb_idx[o]) + 1) % P);
          if (!req_tail[arb_idx[o]]) begin
            olock[o]            <= 1'b1;
            owner[o]            <= arb_idx[o];
            ilock[arb_idx[o]]   <= 1'b1;
            iport[arb_idx[o]]   <= Pw'(o);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_fattree_port_allocator.sv
// Bench for fattree_port_allocator with K=2 (P=4). Directed scenarios plus a
// randomized packet stream, all checked against a packet-level model that
// tracks path ownership with plain integers.
module tb_fattree_port_allocator;
  localparam int K  = 2;
  localparam int P  = 4;
  localparam int PW = 2;
  localparam int FW = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset = 1'b1;
  logic [P-1:0]      req_valid = '0, req_head = '0, req_tail = '0, out_ready = '0;
  logic [P*FW-1:0]   req_destport = '0;
  logic [P-1:0]      grant, out_valid;
  logic [P*PW-1:0]   out_sel;

  fattree_port_allocator #(.K(K)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_head(req_head),
    .req_tail(req_tail), .req_destport(req_destport), .out_ready(out_ready),
    .grant(grant), .out_valid(out_valid), .out_sel(out_sel)
  );

  int    n_cmp = 0;
  int    n_bad = 0;
  string phase = "init";

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s.%s @%0t: got %0h expected %0h", phase, tag, $time, got, exp);
    end
  endtask

  // Model state: own[o] = input holding output o (-1 free),
  // ilk[i] = output held by input i (-1 none), rrp[o] = priority start.
  int own [P];
  int ilk [P];
  int rrp [P];
  int win [P];
  int tgt [P];
  logic [P-1:0]    eg, ev, og;
  logic [P*PW-1:0] es, os;

  function automatic int ohidx(input logic [K-1:0] oh);
    int n, idx;
    n = 0; idx = -1;
    for (int b = 0; b < K; b++) if (oh[b]) begin n++; idx = b; end
    return (n == 1) ? idx : -1;
  endfunction

  task automatic model_eval(input logic r, input logic [P-1:0] v, input logic [P-1:0] hd,
                            input logic [P*FW-1:0] dp, input logic [P-1:0] rdy);
    int x, j, c;
    logic [FW-1:0] f;
    eg = '0; ev = '0; es = '0;
    for (int o = 0; o < P; o++) win[o] = -1;
    if (r) return;
    for (int i = 0; i < P; i++) begin
      tgt[i] = -1;
      f = dp[i*FW +: FW];
      x = ohidx(f[K-1:0]);
      if (ilk[i] < 0 && v[i] && hd[i] && x >= 0) begin
        if (!f[K]) tgt[i] = x;
        else
          for (int s = 0; s < K; s++) begin
            c = K + (x + s) % K;
            if (tgt[i] < 0 && own[c] < 0) tgt[i] = c;
          end
      end
    end
    for (int o = 0; o < P; o++) begin
      if (own[o] >= 0) begin
        if (v[own[o]] && rdy[o]) begin
          eg[own[o]] = 1'b1; ev[o] = 1'b1; es[o*PW +: PW] = PW'(own[o]);
        end
      end else begin
        for (int k = 0; k < P; k++) begin
          j = (rrp[o] + k) % P;
          if (win[o] < 0 && tgt[j] == o && rdy[o]) begin
            win[o] = j; eg[j] = 1'b1; ev[o] = 1'b1; es[o*PW +: PW] = PW'(j);
          end
        end
      end
    end
  endtask

  task automatic model_update(input logic r, input logic [P-1:0] tl);
    if (r) begin
      for (int o = 0; o < P; o++) begin own[o] = -1; ilk[o] = -1; rrp[o] = 0; end
      return;
    end
    for (int o = 0; o < P; o++) begin
      if (own[o] >= 0) begin
        if (eg[own[o]] && tl[own[o]]) begin ilk[own[o]] = -1; own[o] = -1; end
      end else if (win[o] >= 0) begin
        rrp[o] = (win[o] + 1) % P;
        if (!tl[win[o]]) begin own[o] = win[o]; ilk[win[o]] = o; end
      end
    end
  endtask

  task automatic step(input logic r, input logic [P-1:0] v, input logic [P-1:0] hd,
                      input logic [P-1:0] tl, input logic [P*FW-1:0] dp,
                      input logic [P-1:0] rdy);
    @(negedge clk);
    reset = r; req_valid = v; req_head = hd; req_tail = tl;
    req_destport = dp; out_ready = rdy;
    #1;
    model_eval(r, v, hd, dp, rdy);
    og = grant; os = out_sel;
    check("grant", 32'(grant), 32'(eg));
    check("out_valid", 32'(out_valid), 32'(ev));
    check("out_sel", 32'(out_sel), 32'(es));
    @(posedge clk);
    model_update(r, tl);
  endtask

  function automatic logic [P*FW-1:0] dp4(input logic [FW-1:0] a, input logic [FW-1:0] b,
                                          input logic [FW-1:0] c, input logic [FW-1:0] d);
    return {d, c, b, a};
  endfunction

  task automatic do_reset();
    step(1'b1, 4'hF, 4'hF, 4'h0, dp4(3'b001, 3'b001, 3'b001, 3'b001), 4'hF);
  endtask

  initial begin
    logic            r;
    logic [P-1:0]    v, hd, tl, rdy;
    logic [P*FW-1:0] dp;
    logic [K-1:0]    oh;
    logic [FW-1:0]   f;
    bit              inpkt [P];
    int              rem   [P];

    for (int o = 0; o < P; o++) begin own[o] = -1; ilk[o] = -1; rrp[o] = 0; end

    phase = "reset";
    do_reset(); check("rst_g0", 32'(og), 32'h0);
    do_reset(); check("rst_g1", 32'(og), 32'h0);
    step(1'b0, 4'b0001, 4'b0001, 4'b0001, dp4(3'b001, 3'b001, 3'b001, 3'b001), 4'hF);
    check("first_head", 32'(og), 32'h1);

    phase = "contend";
    do_reset();
    step(1'b0, 4'b0011, 4'b0011, 4'b0000, dp4(3'b010, 3'b010, 3'b000, 3'b000), 4'hF);
    check("c0_grant", 32'(og), 32'h1); check("c0_sel1", 32'(os[3:2]), 32'h0);
    step(1'b0, 4'b0011, 4'b0010, 4'b0000, dp4(3'b010, 3'b010, 3'b000, 3'b000), 4'hF);
    check("c1_body", 32'(og), 32'h1);
    step(1'b0, 4'b0011, 4'b0010, 4'b0001, dp4(3'b010, 3'b010, 3'b000, 3'b000), 4'hF);
    check("c2_tail", 32'(og), 32'h1);
    step(1'b0, 4'b0010, 4'b0010, 4'b0010, dp4(3'b000, 3'b010, 3'b000, 3'b000), 4'hF);
    check("c3_in1", 32'(og), 32'h2);
    step(1'b0, 4'b0011, 4'b0011, 4'b0011, dp4(3'b010, 3'b010, 3'b000, 3'b000), 4'hF);
    check("c4_rr", 32'(og), 32'h1);

    phase = "uphint";
    do_reset();
    step(1'b0, 4'b1000, 4'b1000, 4'b0000, dp4(3'b000, 3'b000, 3'b000, 3'b101), 4'hF);
    check("u0_lock2", 32'(og), 32'h8);
    step(1'b0, 4'b1001, 4'b0001, 4'b0001, dp4(3'b101, 3'b000, 3'b000, 3'b101), 4'hF);
    check("u1_grant", 32'(og), 32'h9); check("u1_sel3", 32'(os[7:6]), 32'h0);
    step(1'b0, 4'b1000, 4'b0000, 4'b1000, dp4(3'b000, 3'b000, 3'b000, 3'b000), 4'hF);

    phase = "backpressure";
    do_reset();
    step(1'b0, 4'b0010, 4'b0010, 4'b0000, dp4(3'b000, 3'b001, 3'b000, 3'b000), 4'hF);
    check("b0_lock", 32'(og), 32'h2);
    for (int n = 0; n < 3; n++) begin
      step(1'b0, 4'b0110, 4'b0100, 4'b0000, dp4(3'b000, 3'b001, 3'b001, 3'b000), 4'b1110);
      check("b_stall", 32'(og), 32'h0);
    end
    step(1'b0, 4'b0110, 4'b0100, 4'b0000, dp4(3'b000, 3'b001, 3'b001, 3'b000), 4'hF);
    check("b_resume", 32'(og), 32'h2);
    step(1'b0, 4'b0110, 4'b0100, 4'b0010, dp4(3'b000, 3'b001, 3'b001, 3'b000), 4'hF);
    step(1'b0, 4'b0100, 4'b0100, 4'b0100, dp4(3'b000, 3'b000, 3'b001, 3'b000), 4'hF);
    check("b_after", 32'(og), 32'h4);

    phase = "single";
    do_reset();
    step(1'b0, 4'b0100, 4'b0100, 4'b0100, dp4(3'b000, 3'b000, 3'b001, 3'b000), 4'hF);
    check("s_one", 32'(og), 32'h4);
    step(1'b0, 4'b0001, 4'b0001, 4'b0001, dp4(3'b001, 3'b000, 3'b000, 3'b000), 4'hF);
    check("s_free", 32'(og), 32'h1);
    for (int n = 0; n < 2; n++) begin
      step(1'b0, 4'hF, 4'hF, 4'hF, dp4(3'b011, 3'b011, 3'b011, 3'b011), 4'hF);
      check("illegal", 32'(og), 32'h0);
    end

    phase = "midreset";
    do_reset();
    step(1'b0, 4'b0011, 4'b0011, 4'b0000, dp4(3'b001, 3'b010, 3'b000, 3'b000), 4'hF);
    check("m_lock", 32'(og), 32'h3);
    step(1'b1, 4'b0011, 4'b0000, 4'b0000, dp4(3'b001, 3'b010, 3'b000, 3'b000), 4'hF);
    check("m_rst", 32'(og), 32'h0);
    step(1'b0, 4'b0011, 4'b0011, 4'b0011, dp4(3'b001, 3'b001, 3'b000, 3'b000), 4'hF);
    check("m_rr0", 32'(og), 32'h1);

    phase = "rand";
    do_reset();
    for (int i = 0; i < P; i++) begin inpkt[i] = 1'b0; rem[i] = 0; end
    for (int c = 0; c < 2000; c++) begin
      r = ($urandom_range(299) == 0);
      dp = '0;
      for (int i = 0; i < P; i++) begin
        v[i] = ($urandom_range(9) < 8);
        oh = ($urandom_range(1) == 1) ? 2'b01 : 2'b10;
        if ($urandom_range(9) == 0) oh = ($urandom_range(1) == 1) ? 2'b00 : 2'b11;
        f = {1'($urandom_range(1)), oh};
        dp[i*FW +: FW] = f;
        if (inpkt[i]) begin
          hd[i] = 1'b0; tl[i] = (rem[i] == 1);
        end else begin
          hd[i] = ($urandom_range(19) != 0); tl[i] = ($urandom_range(2) == 0);
        end
        rdy[i] = ($urandom_range(19) < 17);
      end
      step(r, v, hd, tl, dp, rdy);
      for (int i = 0; i < P; i++) begin
        if (r) inpkt[i] = 1'b0;
        else if (eg[i]) begin
          if (!inpkt[i]) begin
            if (!tl[i]) begin inpkt[i] = 1'b1; rem[i] = $urandom_range(3, 1); end
          end else if (tl[i]) inpkt[i] = 1'b0;
          else rem[i] = rem[i] - 1;
        end
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
